// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side arbiter: state encoding and
// default data/FIFO geometry shared with the FIFO itself.
package fifo_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam int DEF_WIDTH = 8;
   localparam int FIFO_SIZE = 16;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: rotate the request vector so rr_ptr lands at bit 0,
// priority-encode the lowest set bit, then rotate the offset back.
module rr_pick #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  i_req_valid,
   input  logic [ID_WIDTH-1:0] i_rr_ptr,
   output logic                o_found,
   output logic [ID_WIDTH-1:0] o_idx
);

   logic [NUM_REQ-1:0]  w_rot;
   logic [ID_WIDTH-1:0] w_off;

   // Modulo-NUM_REQ add; one extra bit keeps the carry for non-power-of-2 counts.
   function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] a,
                                                    input logic [ID_WIDTH-1:0] b);
      logic [ID_WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= (ID_WIDTH+1)'(NUM_REQ)) s = s - (ID_WIDTH+1)'(NUM_REQ);
      return s[ID_WIDTH-1:0];
   endfunction

   always_comb begin
      w_rot   = '0;
      w_off   = '0;
      o_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_rot[k] = i_req_valid[wrap_add(i_rr_ptr, ID_WIDTH'(k))];
      end
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         if (w_rot[k]) begin
            o_found = 1'b1;
            w_off   = ID_WIDTH'(k);
         end
      end
      o_idx = wrap_add(i_rr_ptr, w_off);
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready
// producers, with bursts of up to MAX_BURST beats and a saturating beat counter.
module fifo_wr_arbiter
   import fifo_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 4,
   parameter int CNT_WIDTH = 16,
   localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic                       i_clk,
   input  logic                       i_res,
   input  logic [NUM_REQ-1:0]         i_req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   i_req_data,
   output logic [NUM_REQ-1:0]         o_req_ready,
   output logic                       o_fifo_wr_en,
   output logic [WIDTH-1:0]           o_fifo_wdata,
   input  logic                       i_fifo_full,
   output logic                       o_busy,
   output logic [ID_WIDTH-1:0]        o_grant_id,
   output logic [CNT_WIDTH-1:0]       o_xfer_count
);

   localparam int BC_W = $clog2(MAX_BURST + 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ID_WIDTH-1:0]   r_rr_ptr;
   logic [ID_WIDTH-1:0]   r_grant_id;
   logic [BC_W-1:0]       r_beat_cnt;
   logic [CNT_WIDTH-1:0]  r_xfer_count;

   logic                  w_found;
   logic [ID_WIDTH-1:0]   w_pick;
   logic                  w_cur_valid;
   logic                  w_xfer;
   logic                  w_exit;
   logic [ID_WIDTH-1:0]   w_ptr_nxt;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   rr_pick #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_pick (
      .i_req_valid (i_req_valid),
      .i_rr_ptr    (r_rr_ptr),
      .o_found     (w_found),
      .o_idx       (w_pick)
   );

   assign w_cur_valid = i_req_valid[r_grant_id];
   assign w_ptr_nxt   = (r_grant_id == ID_WIDTH'(NUM_REQ-1)) ? '0 : r_grant_id + 1'b1;

   always_ff @(posedge i_clk or posedge i_res) begin
      if (i_res) begin
         r_state      <= ST_IDLE;
         r_rr_ptr     <= '0;
         r_grant_id   <= '0;
         r_beat_cnt   <= '0;
         r_xfer_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE && w_found) begin
            r_grant_id <= w_pick;
            r_beat_cnt <= '0;
         end
         if (w_xfer) begin
            r_beat_cnt   <= r_beat_cnt + 1'b1;
            r_xfer_count <= sat_inc(r_xfer_count);
         end
         if (w_exit) r_rr_ptr <= w_ptr_nxt;
      end
   end

   // Outputs decode from the current state so reset kills a write at once.
   always_comb begin
      w_state_nxt  = r_state;
      w_xfer       = 1'b0;
      w_exit       = 1'b0;
      o_req_ready  = '0;
      o_fifo_wr_en = 1'b0;
      o_fifo_wdata = '0;
      o_busy       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) w_state_nxt = ST_GRANT;
         end
         ST_GRANT: begin
            o_busy = 1'b1;
            w_xfer = w_cur_valid & ~i_fifo_full;
            w_exit = ~w_cur_valid | (w_xfer & (r_beat_cnt == BC_W'(MAX_BURST-1)));
            if (w_xfer) begin
               o_fifo_wr_en = 1'b1;
               o_req_ready  = NUM_REQ'(1) << r_grant_id;
               o_fifo_wdata = i_req_data[int'(r_grant_id)*WIDTH +: WIDTH];
            end
            if (w_exit) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign o_grant_id   = r_grant_id;
   assign o_xfer_count = r_xfer_count;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with a behavioural 16-deep FIFO fill
// model and a 4-bit-counter twin instance sharing the same stimulus.
module tb_fifo_wr_arbiter;

   logic        clk = 1'b0;
   logic        res;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  ready;
   logic        wr_en;
   logic [7:0]  wdata;
   logic        fifo_full;
   logic        busy;
   logic [1:0]  grant_id;
   logic [15:0] xfer_count;

   logic [3:0]  ready_s;
   logic        wr_en_s;
   logic [7:0]  wdata_s;
   logic        busy_s;
   logic [1:0]  grant_s;
   logic [3:0]  cnt_s;

   logic [7:0]  pdata [4][64];
   int          phead [4] = '{default: 0};
   int          pcount[4] = '{default: 0};

   logic        full_en = 1'b0;
   logic        fclr = 1'b0;
   logic        frd = 1'b0;
   int          fcnt = 0;

   logic [9:0]  sb[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          wr_seen = 0;
   int          cyc = 0;
   int          last_wr_cyc = 0;
   int          exp_total = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.WIDTH(8), .NUM_REQ(4), .MAX_BURST(4), .CNT_WIDTH(16)) dut (
      .i_clk(clk), .i_res(res), .i_req_valid(req_valid), .i_req_data(req_data),
      .o_req_ready(ready), .o_fifo_wr_en(wr_en), .o_fifo_wdata(wdata),
      .i_fifo_full(fifo_full), .o_busy(busy), .o_grant_id(grant_id),
      .o_xfer_count(xfer_count)
   );

   fifo_wr_arbiter #(.WIDTH(8), .NUM_REQ(4), .MAX_BURST(4), .CNT_WIDTH(4)) dut_s (
      .i_clk(clk), .i_res(res), .i_req_valid(req_valid), .i_req_data(req_data),
      .o_req_ready(ready_s), .o_fifo_wr_en(wr_en_s), .o_fifo_wdata(wdata_s),
      .i_fifo_full(fifo_full), .o_busy(busy_s), .o_grant_id(grant_s),
      .o_xfer_count(cnt_s)
   );

   // Producers: each presents its next queued byte until it is accepted.
   always_comb begin
      req_valid = '0;
      req_data  = '0;
      for (int i = 0; i < 4; i++) begin
         req_valid[i]       = phead[i] < pcount[i];
         req_data[i*8 +: 8] = pdata[i][phead[i] & 63];
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 4; i++)
         if (req_valid[i] && ready[i]) phead[i] <= phead[i] + 1;
      if (fclr) fcnt <= 0;
      else      fcnt <= fcnt + (wr_en ? 1 : 0) - (frd ? 1 : 0);
   end

   assign fifo_full = full_en && (fcnt >= 16);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every FIFO write.
   always @(negedge clk) begin
      logic [9:0] e;
      if (wr_en) begin
         wr_seen++;
         last_wr_cyc = cyc;
         if (sb.size() == 0) begin
            check("unexpected_write", {22'b0, grant_id, wdata}, 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            check("wr_beat", {22'b0, grant_id, wdata}, {22'b0, e});
         end
         check("no_overflow", {31'b0, fifo_full}, 32'd0);
         check("ready_onehot", {28'b0, ready}, 32'd1 << grant_id);
      end else begin
         check("idle_outputs", {20'b0, ready, wdata}, 32'd0);
      end
      check("twin_outputs", {16'b0, ready_s, busy_s, grant_s, wr_en_s, wdata_s},
            {16'b0, ready, busy, grant_id, wr_en, wdata});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int id, input logic [7:0] base, input int n);
      for (int k = 0; k < n; k++) pdata[id][pcount[id] + k] = base + 8'(k);
      pcount[id] = pcount[id] + n;
   endtask

   task automatic expect_beats(input logic [1:0] id, input logic [7:0] base, input int n);
      for (int k = 0; k < n; k++) sb.push_back({id, base + 8'(k)});
      exp_total = exp_total + n;
   endtask

   task automatic drain(input string name);
      bit done = 1'b0;
      for (int k = 0; k < 500 && !done; k++) begin
         @(negedge clk);
         if (sb.size() == 0 && !busy && req_valid == 4'b0) done = 1'b1;
      end
      if (!done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s_timeout: %0d beats still expected, expected 0", name, sb.size());
      end
   endtask

   task automatic check_counts(input string name);
      check({name, "_count"}, {16'b0, xfer_count}, exp_total);
      check({name, "_satcount"}, {28'b0, cnt_s}, (exp_total > 15) ? 15 : exp_total);
   endtask

   task automatic do_reset();
      tick();
      res = 1'b1;
      tick();
      res = 1'b0;
      exp_total = 0;
   endtask

   initial begin
      int base;
      int start;
      res = 1'b1;
      repeat (2) @(posedge clk);
      #1 res = 1'b0;
      @(negedge clk);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_wr_en", {31'b0, wr_en}, 0);
      check("rst_grant", {30'b0, grant_id}, 0);
      check("rst_count", {16'b0, xfer_count}, 0);

      // Single requester 1, four beats A0..A3.
      tick();
      load(1, 8'hA0, 4);
      expect_beats(2'd1, 8'hA0, 4);
      @(negedge clk);
      check("t1_bubble", {31'b0, busy}, 0);
      @(negedge clk);
      check("t1_granted", {29'b0, busy, grant_id}, {29'b0, 1'b1, 2'd1});
      drain("t1");
      check("t1_grant_id", {30'b0, grant_id}, 1);
      check_counts("t1");
      // rr_ptr now 2: requester 3 must beat requester 0.
      tick();
      load(0, 8'h50, 1);
      load(3, 8'h40, 1);
      expect_beats(2'd3, 8'h40, 1);
      expect_beats(2'd0, 8'h50, 1);
      drain("t1_rr");

      // All four valid: grants 0,1,2,3,0, 4 beats each, 1-cycle gaps.
      do_reset();
      tick();
      start = cyc;
      load(0, 8'h00, 8);
      load(1, 8'h10, 4);
      load(2, 8'h20, 4);
      load(3, 8'h30, 4);
      expect_beats(2'd0, 8'h00, 4);
      expect_beats(2'd1, 8'h10, 4);
      expect_beats(2'd2, 8'h20, 4);
      expect_beats(2'd3, 8'h30, 4);
      expect_beats(2'd0, 8'h04, 4);
      drain("t2");
      check("t2_last_write_cycle", last_wr_cyc - start, 24);
      check_counts("t2");

      // Fill a 16-deep FIFO from requester 0 with 20 beats offered.
      do_reset();
      tick();
      fclr = 1'b1;
      tick();
      fclr = 1'b0;
      full_en = 1'b1;
      base = wr_seen;
      load(0, 8'h60, 20);
      expect_beats(2'd0, 8'h60, 20);
      repeat (40) @(negedge clk);
      check("t3_writes_at_full", wr_seen - base, 16);
      check("t3_hold_grant", {31'b0, busy}, 1);
      tick();
      frd = 1'b1;
      tick();
      frd = 1'b0;
      repeat (10) @(negedge clk);
      check("t3_one_more", wr_seen - base, 17);
      tick();
      full_en = 1'b0;
      drain("t3");
      check_counts("t3");

      // Early release by requester 2 after 2 beats; rr_ptr moves to 3.
      tick();
      load(2, 8'h80, 2);
      expect_beats(2'd2, 8'h80, 2);
      drain("t4");
      check("t4_grant_id", {30'b0, grant_id}, 2);
      tick();
      load(0, 8'h98, 1);
      load(3, 8'h90, 1);
      expect_beats(2'd3, 8'h90, 1);
      expect_beats(2'd0, 8'h98, 1);
      drain("t4_rr");
      check_counts("t4");

      // Reset in the middle of a 4-beat burst.
      do_reset();
      tick();
      base = wr_seen;
      load(0, 8'hC0, 4);
      expect_beats(2'd0, 8'hC0, 2);
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         if (wr_seen >= base + 2) break;
      end
      #1;
      check("t5_third_beat_live", {31'b0, wr_en}, 1);
      #1 res = 1'b1;
      #1;
      check("t5_rst_wr_en", {31'b0, wr_en}, 0);
      check("t5_rst_ready", {28'b0, ready}, 0);
      check("t5_rst_busy", {31'b0, busy}, 0);
      check("t5_rst_count", {16'b0, xfer_count}, 0);
      exp_total = 0;
      expect_beats(2'd0, 8'hC2, 2);
      @(posedge clk);
      #1 res = 1'b0;
      @(negedge clk);
      check("t5_post_busy", {31'b0, busy}, 0);
      check("t5_post_grant", {30'b0, grant_id}, 0);
      check("t5_post_count", {16'b0, xfer_count}, 0);
      drain("t5");
      check_counts("t5");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one synchronous FIFO write port (wr_en/wdata/full) among NUM_REQ producers.
- Each producer uses a valid/ready handshake.
- The arbiter grants one producer at a time for a burst of up to MAX_BURST beats, then rotates priority.
- It never writes while the FIFO reports full, so FIFO overflow cannot occur from this path.
- It sits directly in front of the FIFO's write side. The FIFO read side is untouched.

Parameters:
- WIDTH, 8: data width; must match the FIFO WIDTH.
- NUM_REQ, 4: number of requesters, 2..16.
- MAX_BURST, 4: maximum beats per grant, at least 1.
- ID_WIDTH, $clog2(NUM_REQ): derived; width of the grant index (localparam).
- CNT_WIDTH, 16: width of the transfer counter.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- res, input, 1: asynchronous active-high reset.
- req_valid, input, NUM_REQ: per-requester data valid.
- req_data, input, NUM_REQ*WIDTH: requester i data at [i*WIDTH +: WIDTH].
- req_ready, output, NUM_REQ: per-requester accept; one-hot or zero.
- fifo_wr_en, output, 1: drives the FIFO wr_en.
- fifo_wdata, output, WIDTH: drives the FIFO wdata.
- fifo_full, input, 1: FIFO full flag.
- busy, output, 1: high while in GRANT.
- grant_id, output, ID_WIDTH: index of the current or last granted requester.
- xfer_count, output, CNT_WIDTH: total beats written; saturates at all-ones.

Behaviour:

Reset:
- Asynchronous on res.
- Registered state: state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, xfer_count=0.
- Because fifo_wr_en, req_ready and busy decode from state, they drop to 0 immediately on reset, including mid-burst. fifo_wdata is driven to 0.

State machine (registered, 2 states):
- IDLE:
  - If any req_valid bit is high, select the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Load grant_id with that index, clear beat_cnt, go to GRANT. The grant is effective the next cycle, so arbitration latency is 1 cycle.
  - If no req_valid bit is high, stay in IDLE.
- GRANT, with g = grant_id:
  - Transfer condition: xfer = req_valid[g] & ~fifo_full.
  - fifo_wr_en = xfer, req_ready[g] = xfer, all other req_ready bits are 0.
  - fifo_wdata = req_data[g] when xfer is high, else 0.
  - On xfer: beat_cnt increments, and xfer_count increments with saturation.
  - Exit on either of:
    - xfer with beat_cnt==MAX_BURST-1 (burst complete), or
    - req_valid[g] low (producer released; no transfer that cycle).
  - On exit: go to IDLE and set rr_ptr = (g+1) mod NUM_REQ. There is always a one-cycle IDLE bubble between grants.
  - While fifo_full is high and req_valid[g] is high, hold the grant indefinitely with no timeout. beat_cnt is unchanged while stalled.

Handshake rules:
- A beat is transferred exactly when req_valid[i] & req_ready[i] on a clock edge.
- Producers must hold data stable while valid and not ready. Dropping valid before acceptance ends the grant.

Full boundary:
- fifo_full is sampled combinationally in the same cycle. The FIFO updates full on the edge after the 16th write, so the 17th write is blocked.
- Consequently the FIFO overflow flag must never assert.

Simultaneous requests:
- Priority rotates only on grant exit. A requester granted with rr_ptr pointing at it is served before any higher index.
- Over N consecutive grants, every persistently valid requester is served once (starvation-free).

Counter:
- xfer_count never wraps; it holds at 2^CNT_WIDTH-1.

Decomposition:
- Package fifo_pkg holds:
  - the state encoding constants (ST_IDLE=1'b0, ST_GRANT=1'b1);
  - the default WIDTH and FIFO_SIZE, shared with the FIFO.
- One natural sub-module is rr_pick. It is combinational: inputs req_valid and rr_ptr, outputs found and the selected index, implemented as a rotate, priority-encode, un-rotate.

Test Plan:
1. Reset then a single requester: req_valid=4'b0010, data 8'hA0..A3 held for 4 beats. Required: IDLE bubble of 1 cycle, then 4 writes with fifo_wdata=A0,A1,A2,A3; grant_id=1; xfer_count=4; rr_ptr=2.
2. All four valid continuously with MAX_BURST=4. Required: grants in order 0,1,2,3,0; 4 beats each with a 1-cycle IDLE gap; req_ready is never multi-hot.
3. Fill a 16-deep FIFO from requester 0 with 20 offered beats. Required: exactly 16 fifo_wr_en pulses; grant held while full; overflow stays 0; on a FIFO read freeing one slot, exactly one more beat is accepted.
4. Early release: requester 2 valid for 2 beats then drops. Required: grant exits after 2 writes; rr_ptr=3; next grant goes to requester 3 if valid.
5. Assert res mid-burst, after 2 of 4 beats. Required: fifo_wr_en and req_ready are 0 in the same cycle; state=IDLE; xfer_count=0; grant_id=0 after release.
6. Saturation with CNT_WIDTH=4: offer 20 beats. Required: xfer_count stops at 15.
